io_bus_ctrl: RTL and testbench

Parametrised memory-mapped I/O bus controller for the MIPS data port. It generalises the fixed four-way read-data select into N devices plus memory, with address-based target decode and a request/acknowledge handshake so slow devices can insert wait states. It adds a timeout watchdog and a bus-error flag, and registers the returned read data. It sits between the core's load/store port and data memory plus the I/O peripherals.

---
 rtl/io_bus_ctrl.sv | 171 +++++++++++++++++
 tb/tb_io_bus_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : io_bus_ctrl
//  Brief    : Memory-mapped I/O bus controller for the MIPS data port.
//             Decodes memory versus N_DEV devices, runs a req/ack handshake
//             with wait states, a timeout watchdog and a bus-error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module io_bus_ctrl #(
    parameter int         N_DEV   = 3,
    parameter int         DW      = 32,
    parameter int         AW      = 32,
    parameter logic [3:0] IO_TAG  = 4'hF,
    parameter int         TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [DW-1:0]       wdata,
    output logic [DW-1:0]       readdata,
    output logic                done,
    output logic                err,
    output logic                busy,
    output logic                bus_we,
    output logic [AW-1:0]       bus_addr,
    output logic [DW-1:0]       bus_wdata,
    output logic                mem_en,
    input  logic                mem_ack,
    input  logic [DW-1:0]       mem_rd,
    output logic [N_DEV-1:0]    dev_en,
    input  logic [N_DEV-1:0]    dev_ack,
    input  logic [N_DEV*DW-1:0] dev_rd
);

    localparam int         c_CW     = $clog2(TIMEOUT);
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [c_CW-1:0] r_cnt;
    logic            r_is_mem;
    logic [3:0]      r_idx;
    logic            r_err;

    logic            w_is_io;
    logic [3:0]      w_idx;
    logic            w_bad;
    logic            w_sel_ack;
    logic [DW-1:0]   w_sel_rd;
    logic            w_timeout;

    // Address decode of the incoming request (only used in IDLE)
    assign w_is_io   = (addr[AW-1 -: 4] == IO_TAG);
    assign w_idx     = addr[11:8];
    assign w_bad     = w_is_io && ({1'b0, w_idx} >= 5'(N_DEV));
    // Last waiting cycle: the counter has seen TIMEOUT-1 ack-less edges
    assign w_timeout = (r_cnt == c_CW'(TIMEOUT - 1));

    // Route only the latched target's ack and read data; others are ignored
    always_comb begin
        w_sel_ack = 1'b0;
        w_sel_rd  = '0;
        if (r_is_mem) begin
            w_sel_ack = mem_ack;
            w_sel_rd  = mem_rd;
        end else begin
            for (int i = 0; i < N_DEV; i++) begin
                if (r_idx == i[3:0]) begin
                    w_sel_ack = dev_ack[i];
                    w_sel_rd  = dev_rd[i*DW +: DW];
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (req) begin
                    w_next = w_bad ? c_DONE : c_ACCESS;
                end
            end
            c_ACCESS: begin
                if (w_sel_ack || w_timeout) begin
                    w_next = c_DONE;
                end
            end
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Request latch, wait counter, error flag and read-data register
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            r_is_mem  <= 1'b0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            readdata  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req) begin
                        bus_we    <= we;
                        bus_addr  <= addr;
                        bus_wdata <= wdata;
                        r_is_mem  <= !w_is_io;
                        r_idx     <= w_idx;
                        r_cnt     <= '0;
                        r_err     <= w_bad;
                    end
                end
                c_ACCESS: begin
                    // Ack beats a coincident timeout
                    if (w_sel_ack) begin
                        r_err <= 1'b0;
                        if (!bus_we) begin
                            readdata <= w_sel_rd;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        if (!bus_we) begin
                            readdata <= '0;
                        end
                    end else begin
                        // Never reaches past TIMEOUT-1, so it cannot wrap
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state and the latched target
    always_comb begin
        busy   = (r_state != c_IDLE);
        done   = (r_state == c_DONE);
        err    = done && r_err;
        mem_en = (r_state == c_ACCESS) && r_is_mem;
        dev_en = '0;
        if ((r_state == c_ACCESS) && !r_is_mem) begin
            for (int i = 0; i < N_DEV; i++) begin
                if (r_idx == i[3:0]) begin
                    dev_en[i] = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_bus_ctrl
//  Brief    : Scoreboard testbench for io_bus_ctrl with a transaction-level
//             reference model and randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_io_bus_ctrl;

    localparam int N_DEV = 3;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int TO    = 15;

    logic                clk = 1'b0;
    logic                reset;
    logic                req;
    logic                we;
    logic [AW-1:0]       addr;
    logic [DW-1:0]       wdata;
    logic [DW-1:0]       readdata;
    logic                done;
    logic                err;
    logic                busy;
    logic                bus_we;
    logic [AW-1:0]       bus_addr;
    logic [DW-1:0]       bus_wdata;
    logic                mem_en;
    logic                mem_ack;
    logic [DW-1:0]       mem_rd;
    logic [N_DEV-1:0]    dev_en;
    logic [N_DEV-1:0]    dev_ack;
    logic [N_DEV*DW-1:0] dev_rd;

    io_bus_ctrl #(
        .N_DEV(N_DEV), .DW(DW), .AW(AW), .IO_TAG(4'hF), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .readdata(readdata), .done(done), .err(err),
        .busy(busy), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .mem_en(mem_en), .mem_ack(mem_ack),
        .mem_rd(mem_rd), .dev_en(dev_en), .dev_ack(dev_ack), .dev_rd(dev_rd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          t0;
        int          lat;
        logic        err;
        logic        chk;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [DW-1:0] m_rd = '0;
    bit          m_known = 1'b1;

    // Monitor: pop one expectation per done pulse
    always @(negedge clk) begin
        exp_t e;
        if (err && !done) begin
            n_cmp++; n_fail++;
            $display("FAIL err_without_done: err=%0b done=%0b", err, done);
        end
        if (done) begin
            if (sb.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_done: got done=1 want no completion");
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if ((cyc - e.t0) != e.lat || err !== e.err) begin
                    n_fail++;
                    $display("FAIL done_timing: latency=%0d err=%0b want latency=%0d err=%0b",
                             cyc - e.t0, err, e.lat, e.err);
                end
                if (e.chk) begin
                    n_cmp++;
                    if (readdata !== e.rd) begin
                        n_fail++;
                        $display("FAIL readdata: got %h want %h", readdata, e.rd);
                    end
                end
            end
        end
    end

    // Issue one transaction; caller is at a negedge with the DUT idle.
    // waits = cycles the selected target holds ack low after enable rises.
    task automatic txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                       input int waits, input logic [DW-1:0] rdv);
        logic           io;
        logic [3:0]     idx;
        logic           bad;
        logic [N_DEV:0] exp_en;
        exp_t           e;
        int             k;
        bit             fin;
        io  = (a[AW-1 -: 4] == 4'hF);
        idx = a[11:8];
        bad = io && (int'(idx) >= N_DEV);
        exp_en = '0;
        if (!bad) begin
            if (io) exp_en[idx + 1] = 1'b1;
            else    exp_en[0]       = 1'b1;
        end
        // Reference model at transaction level
        e.t0 = cyc + 1;
        if (bad) begin
            e.lat = 0; e.err = 1'b1; m_known = 1'b0;
        end else if (waits <= TO - 1) begin
            e.lat = 1 + waits; e.err = 1'b0;
            if (!w) begin m_rd = rdv; m_known = 1'b1; end
        end else begin
            e.lat = TO; e.err = 1'b1;
            if (!w) begin m_rd = '0; m_known = 1'b1; end
        end
        e.chk = m_known;
        e.rd  = m_rd;
        sb.push_back(e);
        mem_rd = io ? DW'($urandom) : rdv;
        dev_rd = {DW'($urandom), DW'($urandom), DW'($urandom)};
        if (io && !bad) dev_rd[idx*DW +: DW] = rdv;
        addr = a; we = w; wdata = wd; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; addr = $urandom; we = 1'($urandom); wdata = $urandom;
        k = 0; fin = 1'b0;
        while (!fin) begin
            if (done) begin
                n_cmp++;
                if ({dev_en, mem_en} !== '0) begin
                    n_fail++;
                    $display("FAIL enables_in_done: got %b want 0", {dev_en, mem_en});
                end
                fin = 1'b1;
            end else if (k > TO + 5) begin
                n_cmp++; n_fail++;
                $display("FAIL no_done: waited %0d cycles want done by %0d", k, TO + 1);
                sb.delete();
                fin = 1'b1;
            end else begin
                n_cmp++;
                if ({dev_en, mem_en} !== exp_en || bus_addr !== a || bus_we !== w ||
                    bus_wdata !== wd) begin
                    n_fail++;
                    $display("FAIL access_bus: en=%b addr=%h we=%b wd=%h want en=%b addr=%h we=%b wd=%h",
                             {dev_en, mem_en}, bus_addr, bus_we, bus_wdata, exp_en, a, w, wd);
                end
                mem_ack = 1'($urandom);
                dev_ack = N_DEV'($urandom);
                if (io) dev_ack[idx] = (k == waits);
                else    mem_ack      = (k == waits);
                k++;
                @(negedge clk);
            end
        end
        mem_ack = 1'b0; dev_ack = '0;
        @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if (readdata !== '0 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 ||
            mem_en !== 1'b0 || dev_en !== '0 || bus_we !== 1'b0 || bus_addr !== '0 ||
            bus_wdata !== '0) begin
            n_fail++;
            $display("FAIL %s: rd=%h done=%b err=%b busy=%b men=%b den=%b bwe=%b ba=%h bwd=%h want all zero",
                     name, readdata, done, err, busy, mem_en, dev_en, bus_we, bus_addr, bus_wdata);
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        int            kind;
        int            wt;
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rd = '0; dev_ack = '0; dev_rd = '0;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        txn(32'h0000_0040, 1'b0, 32'h0,         0,      32'h1234_5678);
        txn(32'hF000_0200, 1'b0, 32'h0,         3,      32'hCAFE_0002);
        txn(32'hF000_0100, 1'b1, 32'hA5A5_A5A5, 0,      32'h0BAD_0001);
        txn(32'hF000_0500, 1'b0, 32'h0,         0,      32'h0);
        txn(32'hF000_0000, 1'b0, 32'h0,         1000,   32'h7777_0000);
        txn(32'hF000_0000, 1'b0, 32'h0,         TO - 1, 32'hBEEF_0000);

        // Reset during a device wait
        sb.push_back('{t0: 0, lat: 0, err: 1'b0, chk: 1'b0, rd: '0});
        addr = 32'hF000_0100; we = 1'b0; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle("reset_mid_access");
        sb.delete();
        m_rd = '0; m_known = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        check_idle("after_reset_release");
        txn(32'h0000_1000, 1'b0, 32'h0, 2, 32'h5555_AAAA);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 4);
            a    = $urandom;
            if (kind <= 1) begin
                a[31:28] = 4'($urandom_range(0, 14));
            end else if (kind <= 3) begin
                a[31:28] = 4'hF;
                a[11:8]  = 4'($urandom_range(0, N_DEV - 1));
            end else begin
                a[31:28] = 4'hF;
                a[11:8]  = 4'($urandom_range(N_DEV, 15));
            end
            case ($urandom_range(0, 7))
                0:       wt = TO - 1;
                1:       wt = TO + $urandom_range(0, 3);
                default: wt = $urandom_range(0, 5);
            endcase
            txn(a, 1'($urandom), $urandom, wt, $urandom);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
